regfile_wb_ctrl: RTL

//  Write-side client of the 16x16 register file. Registers MEM-stage results onto the RF write port.

---
 rtl/regfile_wb_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 16x16 register file: registers MEM results onto the RF write port,
// tracks pending writes for R1..R15, bypasses in-flight results to decode and flags RAW hazards.
module regfile_wb_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [3:0]        issue_dst,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic              wb_kill,
    input  logic [3:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              flush,
    output logic              rf_write_reg,
    output logic [3:0]        rf_dst_reg,
    output logic [DATA_W-1:0] rf_dst_data,
    input  logic              rd_use1,
    input  logic              rd_use2,
    input  logic [3:0]        rd_reg1,
    input  logic [3:0]        rd_reg2,
    output logic [3:0]        rf_src_reg1,
    output logic [3:0]        rf_src_reg2,
    input  logic [DATA_W-1:0] rf_src_data1,
    input  logic [DATA_W-1:0] rf_src_data2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_hazard,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [15:0]       pending_q, pending_d;
    logic              rf_write_q, rf_write_d;
    logic [3:0]        rf_dst_q, rf_dst_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              wb_acc, wb_fwd, iss_acc;
    logic              haz1, haz2;

    // A pending destination may still be re-issued when its own writeback retires this cycle.
    assign wb_ready    = ~flush;
    assign wb_acc      = wb_valid & wb_ready;
    assign wb_fwd      = wb_acc & ~wb_kill;
    assign issue_ready = ~flush & ((issue_dst == 4'd0) | ~pending_q[issue_dst] |
                                   (wb_acc & (wb_dst == issue_dst)));
    assign iss_acc     = issue_valid & issue_ready;

    assign rf_src_reg1 = rd_reg1;
    assign rf_src_reg2 = rd_reg2;

    always_comb begin
        pending_d = pending_q;
        if (wb_acc) begin
            pending_d[wb_dst] = 1'b0;
        end
        if (iss_acc && issue_dst != 4'd0) begin
            pending_d[issue_dst] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rf_write_d = wb_fwd & (wb_dst != 4'd0);
        rf_dst_d   = rf_dst_q;
        rf_data_d  = rf_data_q;
        if (rf_write_d) begin
            rf_dst_d  = wb_dst;
            rf_data_d = wb_data;
        end
    end

    // Youngest value wins: live writeback, then the registered write stage, then the RF array.
    always_comb begin
        rd_data1 = rf_src_data1;
        if (rd_reg1 == 4'd0) begin
            rd_data1 = '0;
        end else if (wb_fwd && wb_dst == rd_reg1) begin
            rd_data1 = wb_data;
        end else if (rf_write_q && rf_dst_q == rd_reg1) begin
            rd_data1 = rf_data_q;
        end

        rd_data2 = rf_src_data2;
        if (rd_reg2 == 4'd0) begin
            rd_data2 = '0;
        end else if (wb_fwd && wb_dst == rd_reg2) begin
            rd_data2 = wb_data;
        end else if (rf_write_q && rf_dst_q == rd_reg2) begin
            rd_data2 = rf_data_q;
        end
    end

    assign haz1 = rd_use1 & (rd_reg1 != 4'd0) & pending_q[rd_reg1] & ~(wb_fwd & (wb_dst == rd_reg1));
    assign haz2 = rd_use2 & (rd_reg2 != 4'd0) & pending_q[rd_reg2] & ~(wb_fwd & (wb_dst == rd_reg2));
    assign rd_hazard = haz1 | haz2;

    always_comb begin
        stall_d = stall_q;
        if (rd_hazard && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= '0;
            rf_write_q <= 1'b0;
            rf_dst_q   <= '0;
            rf_data_q  <= '0;
            stall_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            rf_write_q <= rf_write_d;
            rf_dst_q   <= rf_dst_d;
            rf_data_q  <= rf_data_d;
            stall_q    <= stall_d;
        end
    end

    assign rf_write_reg = rf_write_q;
    assign rf_dst_reg   = rf_dst_q;
    assign rf_dst_data  = rf_data_q;
    assign stall_cnt    = stall_q;

endmodule
